frac_n_mmd: RTL and testbench

FRAC_N_MMD -- requirements
Module: frac_n_mmd

---
 rtl/frac_n_pkg.sv | 12 +
 rtl/frac_n_mmd.sv | 114 +++++++++++
 tb/tb_frac_n_mmd.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_n_pkg.sv
// Shared definitions for the fractional-N divider path (MMD and MASH core).
package frac_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned RATIO_W_DEF   = 4;
  localparam int unsigned MIN_RATIO_DEF = 2;

endpackage

// File: rtl/frac_n_mmd.sv
// Multi-modulus divider: one output period of N clk cycles per consumed ratio,
// with N reloaded at each period boundary from the MASH modulator output.
module frac_n_mmd
  import frac_n_pkg::*;
#(
  parameter int unsigned RATIO_W   = RATIO_W_DEF,
  parameter int unsigned MIN_RATIO = MIN_RATIO_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               ratio_valid,
  input  logic               underrun_clr,
  output logic               ratio_ack,
  output logic               div_clk,
  output logic               div_pulse,
  output logic               underrun,
  output logic [CNT_W-1:0]   period_cnt
);

  localparam logic [RATIO_W-1:0] MIN_N = RATIO_W'(MIN_RATIO);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RATIO_W-1:0] r_phase;
  logic [RATIO_W-1:0] w_phase_nxt;
  logic [RATIO_W-1:0] r_n;
  logic [RATIO_W-1:0] w_n_nxt;
  logic               r_div_clk;
  logic               r_div_pulse;
  logic               r_underrun;
  logic [CNT_W-1:0]   r_period_cnt;
  logic               w_boundary;
  logic               w_load;
  logic               w_ack;
  logic               w_div_clk_nxt;
  logic               w_div_pulse_nxt;
  logic               w_underrun_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  always_comb begin
    w_boundary  = (r_state == ST_RUN) && (r_phase == (r_n - 1'b1));
    // Ack is combinational in the load cycle; gate with rst_n so it is low during reset.
    w_load      = rst_n && en && ((r_state == ST_IDLE) || w_boundary);
    w_ack       = w_load && ratio_valid;

    w_n_nxt = r_n;
    if (w_ack) begin
      w_n_nxt = (ratio < MIN_N) ? MIN_N : ratio;
    end

    w_state_nxt = r_state;
    w_phase_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_boundary) begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from next-cycle phase/N so they line up with r_phase.
    w_div_pulse_nxt = (w_state_nxt == ST_RUN) && (w_phase_nxt == '0);
    w_div_clk_nxt   = (w_state_nxt == ST_RUN) && (w_phase_nxt < (w_n_nxt >> 1));
    w_cnt_nxt       = w_boundary ? (r_period_cnt + 1'b1) : r_period_cnt;

    w_underrun_nxt = r_underrun;
    if (underrun_clr) begin
      w_underrun_nxt = 1'b0;
    end
    if (w_load && !ratio_valid) begin
      w_underrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_n          <= MIN_N;
      r_div_clk    <= 1'b0;
      r_div_pulse  <= 1'b0;
      r_underrun   <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_n          <= w_n_nxt;
      r_div_clk    <= w_div_clk_nxt;
      r_div_pulse  <= w_div_pulse_nxt;
      r_underrun   <= w_underrun_nxt;
      r_period_cnt <= w_cnt_nxt;
    end
  end

  assign ratio_ack  = w_ack;
  assign div_clk    = r_div_clk;
  assign div_pulse  = r_div_pulse;
  assign underrun   = r_underrun;
  assign period_cnt = r_period_cnt;

endmodule

// File: tb/tb_frac_n_mmd.sv
// Scoreboard bench for frac_n_mmd: expected periods are queued by the stimulus,
// and a negedge monitor measures each completed period and compares.
module tb_frac_n_mmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  ratio;
  logic        ratio_valid;
  logic        underrun_clr;
  logic        ratio_ack;
  logic        div_clk;
  logic        div_pulse;
  logic        underrun;
  logic [15:0] period_cnt;

  always #5 clk = ~clk;

  frac_n_mmd #(
    .RATIO_W  (4),
    .MIN_RATIO(2),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ratio       (ratio),
    .ratio_valid (ratio_valid),
    .underrun_clr(underrun_clr),
    .ratio_ack   (ratio_ack),
    .div_clk     (div_clk),
    .div_pulse   (div_pulse),
    .underrun    (underrun),
    .period_cnt  (period_cnt)
  );

  typedef struct {
    int len;
    int hi;
    int acks;
  } per_t;

  per_t        exp_q[$];
  per_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          exp_acks = 0;
  int          obs_acks = 0;
  int          exp_cnt = 0;
  int          cur_len = 0;
  int          cur_hi = 0;
  int          cur_acks = 0;
  bit          in_per = 1'b0;
  logic [15:0] prev_cnt = '0;

  // Modulator model: presents feed_arr[feed_idx], advances one entry per ack.
  logic [3:0]  feed_arr [8];
  logic [3:0]  feed_len = 4'd1;
  logic [2:0]  feed_idx = '0;
  logic        ack_seen = 1'b0;

  assign ratio = feed_arr[feed_idx];

  always @(negedge clk) ack_seen = ratio_ack;

  always @(posedge clk) begin
    #1;
    if (!en) feed_idx = '0;
    else if (ack_seen && ({1'b0, feed_idx} < (feed_len - 4'd1))) feed_idx = feed_idx + 3'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a period_cnt step marks completion of the period being measured.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_per   = 1'b0;
      prev_cnt = '0;
      exp_cnt  = 0;
    end else begin
      if (period_cnt != prev_cnt) begin
        exp_cnt++;
        check("period_cnt", int'(period_cnt), exp_cnt % 65536);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_period: got period_cnt %0d expected no further period", period_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          check("period_len", in_per ? cur_len : 0, mon_e.len);
          check("period_high", in_per ? cur_hi : 0, mon_e.hi);
          check("period_acks", in_per ? cur_acks : 0, mon_e.acks);
        end
        prev_cnt = period_cnt;
        in_per   = 1'b0;
      end
      if (ratio_ack) obs_acks++;
      if (div_pulse) begin
        in_per   = 1'b1;
        cur_len  = 1;
        cur_hi   = int'(div_clk);
        cur_acks = int'(ratio_ack);
      end else if (in_per) begin
        cur_len++;
        cur_hi   += int'(div_clk);
        cur_acks += int'(ratio_ack);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (div_pulse) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no div_pulse expected one within 64 cycles", tag);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d pending periods expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic push(input int len, input int hi, input int acks);
    per_t p;
    p.len  = len;
    p.hi   = hi;
    p.acks = acks;
    exp_q.push_back(p);
  endtask

  task automatic set_feed(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic [3:0] n);
    feed_arr[0] = a;
    feed_arr[1] = b;
    feed_arr[2] = c;
    feed_arr[3] = d;
    feed_len    = n;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) feed_arr[i] = 4'd0;
    rst_n        = 1'b0;
    en           = 1'b1;
    ratio_valid  = 1'b1;
    underrun_clr = 1'b0;
    set_feed(4'd5, 4'd0, 4'd0, 4'd0, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_div_clk", int'(div_clk), 0);
    check("rst_div_pulse", int'(div_pulse), 0);
    check("rst_ratio_ack", int'(ratio_ack), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_period_cnt", int'(period_cnt), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Constant ratio 5
    for (int i = 0; i < 3; i++) push(5, 2, 1);
    push(5, 2, 0);
    exp_acks += 4;
    en = 1'b1;
    for (int i = 0; i < 4; i++) wait_pulse("r5_pulse");
    en = 1'b0;
    drain("r5_drain");
    check("idle_div_clk_r5", int'(div_clk), 0);

    // Ratio sequence 4,5,4,6
    set_feed(4'd4, 4'd5, 4'd4, 4'd6, 4'd4);
    push(4, 2, 1);
    push(5, 2, 1);
    push(4, 2, 1);
    push(6, 3, 0);
    exp_acks += 4;
    en = 1'b1;
    for (int i = 0; i < 4; i++) wait_pulse("seq_pulse");
    en = 1'b0;
    drain("seq_drain");

    // Clamping of 1 and 0, maximum ratio 15
    set_feed(4'd1, 4'd0, 4'd15, 4'd0, 4'd3);
    push(2, 1, 1);
    push(2, 1, 1);
    push(15, 7, 0);
    exp_acks += 3;
    en = 1'b1;
    for (int i = 0; i < 3; i++) wait_pulse("clamp_pulse");
    en = 1'b0;
    drain("clamp_drain");

    // Underrun at one boundary
    set_feed(4'd6, 4'd0, 4'd0, 4'd0, 4'd1);
    check("underrun_pre", int'(underrun), 0);
    push(6, 3, 0);
    push(6, 3, 1);
    push(6, 3, 0);
    exp_acks += 2;
    en = 1'b1;
    wait_pulse("ur_pulse1");
    ratio_valid = 1'b0;
    wait_pulse("ur_pulse2");
    check("underrun_set", int'(underrun), 1);
    ratio_valid = 1'b1;
    wait_pulse("ur_pulse3");
    en = 1'b0;
    drain("ur_drain");
    check("underrun_sticky", int'(underrun), 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_cleared", int'(underrun), 0);

    // en dropped at phase 2 of N=6, then re-raised
    push(6, 3, 0);
    exp_acks += 1;
    en = 1'b1;
    wait_pulse("en_pulse");
    tick();
    tick();
    en = 1'b0;
    drain("en_drain");
    check("idle_div_clk_en", int'(div_clk), 0);
    repeat (4) tick();
    check("idle_hold_div_clk", int'(div_clk), 0);
    check("idle_hold_div_pulse", int'(div_pulse), 0);
    en = 1'b1;
    #1;
    check("reload_ack", int'(ratio_ack), 1);
    push(6, 3, 0);
    exp_acks += 1;
    wait_pulse("reload_pulse");
    en = 1'b0;
    drain("reload_drain");

    // Reset at phase 3 of N=7
    set_feed(4'd7, 4'd0, 4'd0, 4'd0, 4'd1);
    exp_acks += 1;
    en = 1'b1;
    wait_pulse("rst_pulse");
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_div_clk", int'(div_clk), 0);
    check("midrst_div_pulse", int'(div_pulse), 0);
    check("midrst_ratio_ack", int'(ratio_ack), 0);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_period_cnt", int'(period_cnt), 0);
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_period_cnt", int'(period_cnt), 0);

    // Underrun on the first load after reset, clear in the same cycle: set wins, N stays 2
    underrun_clr = 1'b1;
    ratio_valid  = 1'b0;
    en           = 1'b1;
    push(2, 1, 0);
    tick();
    underrun_clr = 1'b0;
    check("underrun_set_wins", int'(underrun), 1);
    wait_pulse("min_pulse");
    en = 1'b0;
    ratio_valid = 1'b1;
    drain("min_drain");

    check("ack_total", obs_acks, exp_acks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
